// File: rtl/window_scan_controller_pkg.sv
// Shared types and constants for the window scan controller.
// Optional feature macro: WINDOW_CTRL_STRIDE_EN (see scan_position_counter).
package window_scan_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ROWADV,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic SHIFT_DIR_H = 1'b1;
  localparam logic SHIFT_DIR_V = 1'b0;

  localparam int DEF_PIXEL_WIDTH = 30;
  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/window_scan_controller_if.sv
// Pixel stream, window array control and window handshake bundle.
// master = upstream/downstream environment, slave = the controller.
interface window_scan_controller_if #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int PIXEL_WIDTH = 30
);
  logic                     start;
  logic [PIXEL_WIDTH-1:0]   pix_in;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [PIXEL_WIDTH-1:0]   pix_out;
  logic                     shift_en;
  logic                     shift_dir;
  logic                     win_valid;
  logic                     win_ready;
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output start, pix_in, pix_valid, win_ready,
    input  pix_ready, pix_out, shift_en, shift_dir, win_valid,
           win_row, win_col, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid, win_ready,
    output pix_ready, pix_out, shift_en, shift_dir, win_valid,
           win_row, win_col, busy, frame_done
  );
endinterface

// File: rtl/window_scan_controller_scan_position_counter.sv
// Column/row tracker for the raster scan plus window-complete qualification.
// With WINDOW_CTRL_STRIDE_EN, wrap-around phase counters enforce the stride.
module scan_position_counter #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WIN_W  = 9,
  parameter int WIN_H  = 9,
  parameter int STRIDE = 1,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          col_inc,
  input  logic          row_adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          row_last,
  output logic          win_ok
);
  logic col_fill, row_fill, stride_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (row_adv) begin
      col <= '0;
      row <= row + 1'b1;
    end else if (col_inc) begin
      col <= col + 1'b1;
    end
  end

  assign col_last = (col == CW'(IMG_W-1));
  assign row_last = (row == RW'(IMG_H-1));
  assign col_fill = (col >= CW'(WIN_W-1));
  assign row_fill = (row >= RW'(WIN_H-1));

`ifdef WINDOW_CTRL_STRIDE_EN
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(STRIDE-1);
  logic [PW-1:0] col_ph, row_ph;

  // Phases count (pos - (WIN-1)) mod STRIDE; they only start moving once
  // the position has passed the fill region.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_ph <= '0;
      row_ph <= '0;
    end else if (clr) begin
      col_ph <= '0;
      row_ph <= '0;
    end else if (row_adv) begin
      col_ph <= '0;
      if (row_fill) row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
    end else if (col_inc) begin
      if (col_fill) col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
    end
  end

  assign stride_ok = (col_ph == '0) && (row_ph == '0);
`else
  // Stride is treated as 1; only a legal (non-zero) setting is meaningful.
  assign stride_ok = (STRIDE >= 1);
`endif

  assign win_ok = col_fill && row_fill && stride_ok;

endmodule

// File: rtl/window_scan_controller.sv
// Frame sequencer for the 2-D shifting-window array: pixel intake, shift
// strobes, window handshake. Optional macro: WINDOW_CTRL_STRIDE_EN.
module window_scan_controller
  import window_scan_controller_pkg::*;
#(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int WIN_W       = 9,
  parameter int WIN_H       = 9,
  parameter int PIXEL_WIDTH = 30,
  parameter int STRIDE      = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  window_scan_controller_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_e                 state, nstate;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic                   col_last, row_last, win_ok;
  logic                   clr, col_inc, row_adv;
  logic                   accept, win_take;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic                   shift_en_q, shift_dir_q, win_valid_q, busy_q;

  scan_position_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_W(WIN_W), .WIN_H(WIN_H), .STRIDE(STRIDE)
  ) u_pos (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .col_inc  (col_inc),
    .row_adv  (row_adv),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last),
    .win_ok   (win_ok)
  );

  assign accept   = (state == ST_SCAN) && bus.pix_valid;
  assign win_take = win_valid_q && bus.win_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    clr     = 1'b0;
    col_inc = 1'b0;
    row_adv = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        nstate = ST_SCAN;
        clr    = 1'b1;
      end
      ST_SCAN: if (accept) begin
        if (win_ok)        nstate = ST_HOLD;
        else if (col_last) nstate = ST_ROWADV;
        else               col_inc = 1'b1;
      end
      ST_HOLD: if (win_take) begin
        if (col_last && row_last) nstate = ST_DONE;
        else if (col_last)        nstate = ST_ROWADV;
        else begin
          col_inc = 1'b1;
          nstate  = ST_SCAN;
        end
      end
      ST_ROWADV: begin
        if (row_last) nstate = ST_DONE;
        else begin
          row_adv = 1'b1;
          nstate  = ST_SCAN;
        end
      end
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // win_valid rises one cycle after entering HOLD so the array has applied
  // the completing shift before the window is offered downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_q       <= '0;
      shift_en_q  <= 1'b0;
      shift_dir_q <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      if (accept) begin
        pix_q       <= bus.pix_in;
        shift_en_q  <= 1'b1;
        shift_dir_q <= SHIFT_DIR_H;
      end else if (state == ST_ROWADV && !row_last) begin
        shift_en_q  <= 1'b1;
        shift_dir_q <= SHIFT_DIR_V;
      end
      win_valid_q <= (state == ST_HOLD) && !win_take;
      if (state == ST_IDLE && bus.start) busy_q <= 1'b1;
      else if (state == ST_DONE)         busy_q <= 1'b0;
    end
  end

  assign bus.pix_ready  = (state == ST_SCAN);
  assign bus.pix_out    = pix_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.shift_dir  = shift_dir_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = row;
  assign bus.win_col    = col;
  assign bus.busy       = busy_q;
  assign bus.frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_window_scan_controller.sv
// Self-checking bench: table of frame scenarios plus reset/backpressure
// sequences, with an ordered event scoreboard for shifts and windows.
module tb_window_scan_controller;
  import window_scan_controller_pkg::*;

`ifdef WINDOW_CTRL_STRIDE_EN
  localparam int IW = 5, IH = 5, ST = 2;
  localparam int EXP_W = ((IW-3)/ST + 1) * ((IH-3)/ST + 1);
`else
  localparam int IW = 4, IH = 4, ST = 1;
  localparam int EXP_W = (IW-3+1) * (IH-3+1);
`endif
  localparam int WW = 3, WH = 3;
  localparam int PW = DEF_PIXEL_WIDTH;
  localparam int BUDGET = 2000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  window_scan_controller_if #(.IMG_W(IW), .IMG_H(IH), .PIXEL_WIDTH(PW)) bus ();

  window_scan_controller #(
    .IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .PIXEL_WIDTH(PW), .STRIDE(ST)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 0 = horizontal shift, 1 = vertical shift, 2 = window handshake
  typedef struct {
    int     kind;
    pixel_t data;
    int     row;
    int     col;
  } ev_t;

  typedef struct {
    int mode;     // 0 plain, 1 bubbles, 2 start while busy, 3 random, 4 backpressure
    int base;
    int exp_h;
    int exp_v;
    int exp_w;
    int exp_done;
  } vec_t;

  ev_t  expq[$];
  vec_t tbl[5];
  int   checks = 0, failures = 0;
  int   n_h, n_v, n_w, n_done;
  int   first_win_idx;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=none", name, act);
  endtask

  function automatic bit is_win(input int r, input int c);
    if (c < WW-1 || r < WH-1) return 1'b0;
`ifdef WINDOW_CTRL_STRIDE_EN
    return ((c-(WW-1)) % ST == 0) && ((r-(WH-1)) % ST == 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic build_expect(input int base);
    ev_t e;
    expq.delete();
    first_win_idx = -1;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        e.kind = 0; e.data = pixel_t'(base + r*IW + c); e.row = r; e.col = c;
        expq.push_back(e);
        if (is_win(r, c)) begin
          e.kind = 2;
          expq.push_back(e);
          if (first_win_idx < 0) first_win_idx = r*IW + c;
        end
        if (c == IW-1 && r < IH-1) begin
          e.kind = 1;
          expq.push_back(e);
        end
      end
    end
  endtask

  task automatic mon_cycle();
    ev_t e;
    if (bus.shift_en) begin
      if (bus.shift_dir) n_h++; else n_v++;
      if (expq.size() == 0) fail_now("shift_unexpected", longint'(bus.shift_dir));
      else begin
        e = expq.pop_front();
        chk("shift_kind", bus.shift_dir ? 0 : 1, e.kind);
        if (bus.shift_dir && e.kind == 0) chk("pix_out", longint'(bus.pix_out), longint'(e.data));
      end
    end
    if (bus.win_valid && bus.win_ready) begin
      n_w++;
      if (expq.size() == 0) fail_now("win_unexpected", longint'(bus.win_col));
      else begin
        e = expq.pop_front();
        chk("win_kind", 2, e.kind);
        chk("win_row", longint'(bus.win_row), e.row);
        chk("win_col", longint'(bus.win_col), e.col);
      end
    end
    if (bus.win_valid) chk("hold_stall", longint'({bus.shift_en, bus.pix_ready}), 0);
    if (bus.frame_done) n_done++;
  endtask

  task automatic run_frame(input vec_t v);
    int  idx, cyc, hold_cnt;
    bit  acc;
    build_expect(v.base);
    n_h = 0; n_v = 0; n_w = 0; n_done = 0;
    idx = 0; cyc = 0; hold_cnt = 0;
    while (n_done == 0 && cyc < BUDGET) begin
      bus.start     = (cyc == 0) || (v.mode == 2 && cyc == 3);
      bus.pix_in    = PW'(v.base + idx);
      bus.pix_valid = (idx < IW*IH) &&
                      (v.mode == 1 ? (cyc % 2 == 1) :
                       v.mode == 3 ? ($urandom_range(0, 1) == 1) : 1'b1);
      bus.win_ready = (v.mode == 3) ? ($urandom_range(0, 1) == 1) :
                      (v.mode == 4) ? (hold_cnt >= 5) : 1'b1;
      @(negedge clock);
      mon_cycle();
      acc = bus.pix_valid && bus.pix_ready;
      if (v.mode == 4 && bus.win_valid && !bus.win_ready) begin
        chk("bp_win_valid", longint'(bus.win_valid), 1);
        chk("bp_pix_ready", longint'(bus.pix_ready), 0);
        chk("bp_shift_en", longint'(bus.shift_en), 0);
        chk("bp_pixels_taken", idx, first_win_idx + 1);
        hold_cnt++;
      end
      @(posedge clock);
      #1;
      if (acc) idx++;
      cyc++;
    end
    if (n_done == 0) fail_now("frame_timeout", cyc);
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.win_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      mon_cycle();
      @(posedge clock);
      #1;
    end
    chk("h_shifts", n_h, v.exp_h);
    chk("v_shifts", n_v, v.exp_v);
    chk("windows", n_w, v.exp_w);
    chk("frame_done_cnt", n_done, v.exp_done);
    chk("events_left", expq.size(), 0);
    chk("busy_after", longint'(bus.busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_ready"},  longint'(bus.pix_ready), 0);
    chk({tag, "_shift_en"},   longint'(bus.shift_en), 0);
    chk({tag, "_shift_dir"},  longint'(bus.shift_dir), 0);
    chk({tag, "_pix_out"},    longint'(bus.pix_out), 0);
    chk({tag, "_win_valid"},  longint'(bus.win_valid), 0);
    chk({tag, "_win_row"},    longint'(bus.win_row), 0);
    chk({tag, "_win_col"},    longint'(bus.win_col), 0);
    chk({tag, "_busy"},       longint'(bus.busy), 0);
    chk({tag, "_frame_done"}, longint'(bus.frame_done), 0);
  endtask

  initial begin
    tbl[0] = '{mode: 0, base: 1,    exp_h: IW*IH, exp_v: IH-1, exp_w: EXP_W, exp_done: 1};
    tbl[1] = '{mode: 1, base: 100,  exp_h: IW*IH, exp_v: IH-1, exp_w: EXP_W, exp_done: 1};
    tbl[2] = '{mode: 2, base: 200,  exp_h: IW*IH, exp_v: IH-1, exp_w: EXP_W, exp_done: 1};
    tbl[3] = '{mode: 3, base: 300,  exp_h: IW*IH, exp_v: IH-1, exp_w: EXP_W, exp_done: 1};
    tbl[4] = '{mode: 4, base: 400,  exp_h: IW*IH, exp_v: IH-1, exp_w: EXP_W, exp_done: 1};

    bus.start = 1'b0; bus.pix_in = '0; bus.pix_valid = 1'b0; bus.win_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("rst");
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_busy", longint'(bus.busy), 0);
    chk("idle_pix_ready", longint'(bus.pix_ready), 0);

    // Abort a frame mid-scan: outputs drop immediately, no frame_done follows.
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0; bus.pix_valid = 1'b1; bus.pix_in = PW'(77);
    repeat (3) @(posedge clock);
    #1;
    chk("mid_busy", longint'(bus.busy), 1);
    chk("mid_shift_en", longint'(bus.shift_en), 1);
    chk("mid_pix_out", longint'(bus.pix_out), 77);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    bus.pix_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_done = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.frame_done) n_done++;
      chk("post_abort_busy", longint'(bus.busy), 0);
      @(posedge clock);
      #1;
    end
    chk("post_abort_done", n_done, 0);
    chk("post_abort_ready", longint'(bus.pix_ready), 0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_scan_controller.md
Name: window_scan_controller

Overview:
- Sequences the 2-D shifting-window register array for one image frame.
- Accepts a raster-order pixel stream (valid/ready), forwards each pixel to the array's edge input and drives shift_en/shift_dir: a horizontal shift per pixel, a vertical shift per row end.
- Tracks row/column position, flags when the array holds a complete, stride-aligned window, and holds the array while the downstream convolution unit is busy.

Parameters:
- IMG_W, 28, pixels per image row (>= WIN_W)
- IMG_H, 28, rows per image (>= WIN_H)
- WIN_W, 9, window width
- WIN_H, 9, window height
- PIXEL_WIDTH, 30, bits per pixel
- STRIDE, 1, window step in both axes (used only with WINDOW_CTRL_STRIDE_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
- pix_in  in  PIXEL_WIDTH  incoming pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  controller accepts pix_in this cycle
- pix_out  out  PIXEL_WIDTH  pixel to the window array edge input
- shift_en  out  1  window array shift strobe
- shift_dir  out  1  1 = horizontal (left to right), 0 = vertical (top to bottom)
- win_valid  out  1  array holds a complete window
- win_ready  in  1  downstream consumed the window
- win_row  out  clog2(IMG_H)  row index of the window's bottom-right pixel
- win_col  out  clog2(IMG_W)  column index of the window's bottom-right pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the final window is consumed

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame; no frame_done.
- States: IDLE, SCAN, ROWADV, HOLD, DONE.
- IDLE: pix_ready=0, busy=0. start -> SCAN next cycle; col=row=0, busy=1.
- SCAN:
  - pix_ready = 1.
  - On pix_valid & pix_ready: pix_out<=pix_in, shift_en<=1, shift_dir<=1 (all registered, one-cycle latency).
  - Window check uses the current col/row: col>=WIN_W-1, row>=WIN_H-1, and stride alignment.
  - If the window check passes, next state is HOLD. Else, if col==IMG_W-1, next state is ROWADV. Else col++.
- HOLD:
  - win_valid=1 (asserted the cycle after the completing shift), pix_ready=0, shift_en=0. win_row/win_col stable.
  - On win_valid & win_ready: win_valid<=0.
    - Last pixel (col==IMG_W-1, row==IMG_H-1): go to DONE.
    - col==IMG_W-1 otherwise: go to ROWADV.
    - Otherwise: col++, return to SCAN.
- ROWADV:
  - Exactly one cycle: shift_en=1, shift_dir=0, no pixel consumed, pix_ready=0.
  - col<=0, row++; then SCAN.
  - If row==IMG_H-1 with no window pending, go to DONE instead.
- DONE: frame_done=1 for one cycle, busy<=0, then IDLE.
- Stride alignment without the macro: always true (stride 1).
- shift_en is never asserted in HOLD. A pixel is never accepted while win_valid=1.
- Simultaneous events:
  - start outside IDLE: ignored.
  - pix_valid in HOLD/ROWADV: stalled (ready low), pixel retained by upstream.
- Windows per frame (stride 1): (IMG_W-WIN_W+1)*(IMG_H-WIN_H+1); 400 at defaults.

Optional Feature:
- Macro: WINDOW_CTRL_STRIDE_EN.
- Defined: stride alignment requires (col-(WIN_W-1)) mod STRIDE==0 and (row-(WIN_H-1)) mod STRIDE==0. Tracked with wrap-around phase counters, no dividers. Shifts still occur for every pixel.
- Undefined: STRIDE ignored; every position past the fill region yields a window.

Decomposition:
- Shared package: state enum (IDLE/SCAN/ROWADV/HOLD/DONE), SHIFT_DIR_H=1 / SHIFT_DIR_V=0 constants, pixel typedef of PIXEL_WIDTH bits.
- One sub-module: scan_position_counter (col/row counters, wrap and end-of-row/frame flags, optional stride phase counters).

Test Plan (IMG_W=IMG_H=4, WIN_W=WIN_H=3 unless stated):
- Reset: reset high mid-SCAN -> all outputs 0 same cycle; IDLE after release; no frame_done.
- Full frame, win_ready tied 1, pix_valid tied 1, pixels 1..16 -> 16 horizontal shifts, 3 vertical shifts, 4 win_valid pulses at (row,col)=(2,2),(2,3),(3,2),(3,3); frame_done once.
- Backpressure: win_ready low 5 cycles at the first window -> win_valid held, pix_ready=0, shift_en=0, pixel 12 not consumed until release.
- Bubbles: pix_valid toggling every other cycle -> same shift sequence and 4 windows; shift_en only on accepted pixels.
- start during busy -> ignored; frame completes normally with 4 windows.
- WINDOW_CTRL_STRIDE_EN, IMG 5x5, STRIDE=2 -> windows only at (2,2),(2,4),(4,2),(4,4); 25 horizontal shifts, 4 vertical shifts.
